q_6_24_seq_checker: RTL and testbench
=====================================

Name: q_6_24_seq_checker

Overview:
- Receive-side checker for the six-state 3-bit sequence 000→001→011→111→110→100→000 produced by the sequence generator.
- Samples the generator's count bus when `en` is high and decodes each code to a phase index.
- Acquires and holds lock using a flywheel state machine, and flags, counts and tolerates corrupted or illegal codes, including the illegal 101 the generator outputs during reset.
- Sits at the consuming end of the count bus, synchronous to the same clk.

Parameters:
- LOCK_CNT, 3, consecutive correct transitions needed in CONFIRM to declare lock (≥1).
- UNLOCK_CNT, 2, consecutive errors in LOCKED that drop lock (≥1).
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rstb  input  1  asynchronous active-low reset.
- en  input  1  sample strobe; code_in is evaluated only when en=1.
- code_in  input  3  observed sequence code.
- clr_err  input  1  synchronous clear of err_count.
- phase  output  3  registered decode of last sample: 000→0, 001→1, 011→2, 111→3, 110→4, 100→5, illegal (010/101)→7.
- code_legal  output  1  last sample was one of the six legal codes.
- locked  output  1  FSM in LOCKED.
- err_pulse  output  1  one-cycle pulse; error detected while LOCKED.
- wrap_pulse  output  1  one-cycle pulse; correct 100→000 transition while LOCKED.
- err_count  output  ERR_W  saturating count of err_pulse events.

Behaviour:
- Reset (async, rstb=0):
  - FSM=SEARCH, prev_valid=0, prev=000, good_cnt=0, bad_cnt=0.
  - phase=7, code_legal=0, locked=0, err_pulse=0, wrap_pulse=0, err_count=0.
  - Reset asserted mid-operation aborts everything immediately.
- en=0: all state holds; err_pulse and wrap_pulse are 0; phase and code_legal hold.
- Latency:
  - All outputs are registered and reflect the sample taken at edge N after edge N.
  - locked rises/falls at the edge that processes the deciding sample.
- Definitions, per sample:
  - expected = next(prev).
  - correct = prev_valid && code_in==expected.
  - error = illegal code_in, OR (prev_valid && code_in≠expected).
- SEARCH:
  - Legal sample → CONFIRM, prev=code_in, prev_valid=1, good_cnt=0.
  - Illegal sample → stay in SEARCH.
  - No err_pulse is generated in SEARCH.
- CONFIRM:
  - correct → good_cnt+1 and prev=code_in; when good_cnt+1==LOCK_CNT → LOCKED with bad_cnt=0.
  - Legal mismatch → stay in CONFIRM, good_cnt=0, prev=code_in.
  - Illegal → SEARCH, prev_valid=0.
  - No err_pulse is generated in CONFIRM.
- LOCKED:
  - correct → bad_cnt=0, prev=code_in; wrap_pulse=1 if prev was 100 and code_in is 000.
  - error → err_pulse=1, bad_cnt+1, prev=expected (flywheel: assume the sample was corrupted and keep the expected sequence running).
  - When bad_cnt+1==UNLOCK_CNT → SEARCH, prev_valid=0, locked=0. err_pulse is still asserted for this final error.
- err_count:
  - Increments on each err_pulse and saturates at all-ones.
  - clr_err forces 0 and takes priority over a simultaneous increment.
- Widths:
  - good_cnt is $clog2(LOCK_CNT+1) bits.
  - bad_cnt is $clog2(UNLOCK_CNT+1) bits.
  - No wrap on either counter.

Decomposition:
- Package q_6_24_pkg holds:
  - code constants S0..S5 (000, 001, 011, 111, 110, 100);
  - PHASE_ILLEGAL=3'd7;
  - the FSM state typedef {SEARCH, CONFIRM, LOCKED}.
- The generator is refactored to import the same constants.
- Sub-module q_6_24_code_decode is purely combinational. It maps code to {phase, legal, next_code}, with next of an illegal code = 000. The checker instantiates it twice: once on code_in and once on prev.

Test Plan:
- Lock acquisition, en=1 every cycle: after reset, drive 101, 000, 001, 011, 111 → 101 gives phase=7, code_legal=0, no lock; locked=1 after the 111 sample; err_count=0.
- Wrap: continue locked with 110, 100, 000 → phases 4, 5, 0; wrap_pulse=1 only for the 000 sample; err_pulse stays 0.
- Flywheel single error: locked at 001, drive 010 (illegal) then 111 → err_pulse on 010, phase=7; 111 matches the flywheel expectation (next of 011) so bad_cnt resets; locked stays 1; err_count=1.
- Loss of lock: locked at 000, drive 110, 110 → err_pulse twice, locked=0 after the second, err_count=2; then 000, 001, 011, 111 → relocks.
- en gating and clear: toggle en=0 mid-sequence with garbage on code_in → no state change and no pulses. Preload err_count=255 (ERR_W=8), inject an error → count stays 255. Assert clr_err together with an error → count=0.
- Async reset while LOCKED with err_count=5 → all outputs return to reset values immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/q_6_24_pkg.sv
// ---------------------------------------------------------------------------
// q_6_24_pkg
// Shared definitions for the six-state 3-bit sequence
// 000 -> 001 -> 011 -> 111 -> 110 -> 100 -> 000.
// Contents:
//   S0..S5        legal codes in sequence order (phase index 0..5)
//   PHASE_ILLEGAL phase value reported for 010/101
//   chk_state_t   checker flywheel FSM states
// Both the sequence generator and the receive-side checker import this, so
// the two ends of the count bus always agree on the code table.
// ---------------------------------------------------------------------------
package q_6_24_pkg;

   localparam logic [2:0] S0 = 3'b000;
   localparam logic [2:0] S1 = 3'b001;
   localparam logic [2:0] S2 = 3'b011;
   localparam logic [2:0] S3 = 3'b111;
   localparam logic [2:0] S4 = 3'b110;
   localparam logic [2:0] S5 = 3'b100;

   localparam logic [2:0] PHASE_ILLEGAL = 3'd7;

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      CONFIRM = 2'd1,
      LOCKED  = 2'd2
   } chk_state_t;

endpackage

// File: rtl/q_6_24_seq_checker_if.sv
// ---------------------------------------------------------------------------
// q_6_24_seq_checker_if
// Bus bundle between the consumer of the checker and the checker itself.
// Ports (as seen from the checker / slave side):
//   en          in   sample strobe
//   code_in     in   observed 3-bit sequence code
//   clr_err     in   synchronous clear of err_count
//   phase       out  decoded phase of last sample (7 = illegal)
//   code_legal  out  last sample was a legal code
//   locked      out  checker is locked to the sequence
//   err_pulse   out  one-cycle error strobe while locked
//   wrap_pulse  out  one-cycle strobe on a correct 100->000 while locked
//   err_count   out  saturating count of err_pulse events
// ---------------------------------------------------------------------------
interface q_6_24_seq_checker_if #(
   parameter int ERR_W = 8
);

   logic             en;
   logic [2:0]       code_in;
   logic             clr_err;
   logic [2:0]       phase;
   logic             code_legal;
   logic             locked;
   logic             err_pulse;
   logic             wrap_pulse;
   logic [ERR_W-1:0] err_count;

   modport master (
      output en,
      output code_in,
      output clr_err,
      input  phase,
      input  code_legal,
      input  locked,
      input  err_pulse,
      input  wrap_pulse,
      input  err_count
   );

   modport slave (
      input  en,
      input  code_in,
      input  clr_err,
      output phase,
      output code_legal,
      output locked,
      output err_pulse,
      output wrap_pulse,
      output err_count
   );

endinterface

// File: rtl/q_6_24_code_decode.sv
// ---------------------------------------------------------------------------
// q_6_24_code_decode
// Purely combinational decoder for one sequence code.
// Ports:
//   code       in   3-bit code
//   phase      out  position in the sequence 0..5, or 7 for 010/101
//   legal      out  code is one of the six sequence codes
//   next_code  out  code that should follow; 000 for an illegal code
// ---------------------------------------------------------------------------
module q_6_24_code_decode
   import q_6_24_pkg::*;
(
   input  logic [2:0] code,
   output logic [2:0] phase,
   output logic       legal,
   output logic [2:0] next_code
);

   // Table lookup; illegal codes fall through to the defaults, which restart
   // the expected sequence at 000.
   always_comb begin
      phase     = PHASE_ILLEGAL;
      legal     = 1'b0;
      next_code = S0;
      case (code)
         S0: begin
            phase     = 3'd0;
            legal     = 1'b1;
            next_code = S1;
         end
         S1: begin
            phase     = 3'd1;
            legal     = 1'b1;
            next_code = S2;
         end
         S2: begin
            phase     = 3'd2;
            legal     = 1'b1;
            next_code = S3;
         end
         S3: begin
            phase     = 3'd3;
            legal     = 1'b1;
            next_code = S4;
         end
         S4: begin
            phase     = 3'd4;
            legal     = 1'b1;
            next_code = S5;
         end
         S5: begin
            phase     = 3'd5;
            legal     = 1'b1;
            next_code = S0;
         end
         default: begin
            phase     = PHASE_ILLEGAL;
            legal     = 1'b0;
            next_code = S0;
         end
      endcase
   end

endmodule

// File: rtl/q_6_24_seq_checker.sv
// ---------------------------------------------------------------------------
// q_6_24_seq_checker
// Receive-side checker for the 000->001->011->111->110->100 sequence.
// Acquires lock through SEARCH -> CONFIRM -> LOCKED and, once locked, rides
// through isolated corrupted samples (flywheel) while flagging and counting
// them. Lock is dropped after UNLOCK_CNT consecutive errors.
// Ports:
//   clk   in  clock, rising edge
//   rstb  in  asynchronous active-low reset
//   bus   q_6_24_seq_checker_if.slave (en, code_in, clr_err in;
//         phase, code_legal, locked, err_pulse, wrap_pulse, err_count out)
// Parameters:
//   LOCK_CNT    consecutive correct transitions in CONFIRM to lock (>=1)
//   UNLOCK_CNT  consecutive errors in LOCKED to drop lock (>=1)
//   ERR_W       width of err_count; must match the interface
// ---------------------------------------------------------------------------
module q_6_24_seq_checker
   import q_6_24_pkg::*;
#(
   parameter int LOCK_CNT   = 3,
   parameter int UNLOCK_CNT = 2,
   parameter int ERR_W      = 8
)
(
   input  logic                    clk,
   input  logic                    rstb,
   q_6_24_seq_checker_if.slave     bus
);

   localparam int GW = $clog2(LOCK_CNT + 1);
   localparam int BW = $clog2(UNLOCK_CNT + 1);

   chk_state_t       state_q, state_nxt;
   logic [2:0]       prev_q, prev_nxt;
   logic             prev_valid_q, prev_valid_nxt;
   logic [GW-1:0]    good_q, good_nxt, good_inc;
   logic [BW-1:0]    bad_q, bad_nxt, bad_inc;
   logic [2:0]       phase_q, phase_nxt;
   logic             legal_q, legal_nxt;
   logic             locked_q;
   logic             err_pulse_q, err_pulse_nxt;
   logic             wrap_pulse_q, wrap_pulse_nxt;
   logic [ERR_W-1:0] err_cnt_q;

   logic [2:0]       in_phase;
   logic             in_legal;
   logic [2:0]       in_next_unused;
   logic [2:0]       prev_phase;
   logic             prev_legal;
   logic [2:0]       expected;
   logic             exp_valid;
   logic             correct;

   // Decode of the incoming sample; its successor code is not needed here.
   q_6_24_code_decode u_dec_in (
      .code      (bus.code_in),
      .phase     (in_phase),
      .legal     (in_legal),
      .next_code (in_next_unused)
   );

   // Decode of the last accepted code gives the expected next code.
   q_6_24_code_decode u_dec_prev (
      .code      (prev_q),
      .phase     (prev_phase),
      .legal     (prev_legal),
      .next_code (expected)
   );

   // prev_q is always legal when valid; folding in prev_legal just keeps an
   // impossible illegal prev from ever being treated as a reference.
   assign exp_valid = prev_valid_q && prev_legal;
   assign correct   = exp_valid && (bus.code_in == expected);
   assign good_inc  = good_q + GW'(1);
   assign bad_inc   = bad_q + BW'(1);

   // Next-state and registered-output logic. Everything holds while en is
   // low; pulses default to zero so they last exactly one sampled cycle.
   always_comb begin
      state_nxt      = state_q;
      prev_nxt       = prev_q;
      prev_valid_nxt = prev_valid_q;
      good_nxt       = good_q;
      bad_nxt        = bad_q;
      phase_nxt      = phase_q;
      legal_nxt      = legal_q;
      err_pulse_nxt  = 1'b0;
      wrap_pulse_nxt = 1'b0;

      if (bus.en) begin
         phase_nxt = in_phase;
         legal_nxt = in_legal;

         case (state_q)
            SEARCH: begin
               if (in_legal) begin
                  state_nxt      = CONFIRM;
                  prev_nxt       = bus.code_in;
                  prev_valid_nxt = 1'b1;
                  good_nxt       = '0;
               end
            end

            CONFIRM: begin
               if (!in_legal) begin
                  state_nxt      = SEARCH;
                  prev_valid_nxt = 1'b0;
               end else if (correct) begin
                  good_nxt = good_inc;
                  prev_nxt = bus.code_in;
                  if (good_inc == GW'(LOCK_CNT)) begin
                     state_nxt = LOCKED;
                     bad_nxt   = '0;
                  end
               end else begin
                  good_nxt = '0;
                  prev_nxt = bus.code_in;
               end
            end

            LOCKED: begin
               if (correct) begin
                  bad_nxt        = '0;
                  prev_nxt       = bus.code_in;
                  wrap_pulse_nxt = (prev_phase == 3'd5) && (in_phase == 3'd0);
               end else begin
                  // Flywheel: treat the sample as corrupted and advance the
                  // reference as if the expected code had arrived.
                  err_pulse_nxt = 1'b1;
                  bad_nxt       = bad_inc;
                  prev_nxt      = expected;
                  if (bad_inc == BW'(UNLOCK_CNT)) begin
                     state_nxt      = SEARCH;
                     prev_valid_nxt = 1'b0;
                  end
               end
            end

            default: begin
               state_nxt      = SEARCH;
               prev_valid_nxt = 1'b0;
            end
         endcase
      end
   end

   // State and output registers; reset aborts everything asynchronously.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q      <= SEARCH;
         prev_q       <= S0;
         prev_valid_q <= 1'b0;
         good_q       <= '0;
         bad_q        <= '0;
         phase_q      <= PHASE_ILLEGAL;
         legal_q      <= 1'b0;
         locked_q     <= 1'b0;
         err_pulse_q  <= 1'b0;
         wrap_pulse_q <= 1'b0;
      end else begin
         state_q      <= state_nxt;
         prev_q       <= prev_nxt;
         prev_valid_q <= prev_valid_nxt;
         good_q       <= good_nxt;
         bad_q        <= bad_nxt;
         phase_q      <= phase_nxt;
         legal_q      <= legal_nxt;
         locked_q     <= (state_nxt == LOCKED);
         err_pulse_q  <= err_pulse_nxt;
         wrap_pulse_q <= wrap_pulse_nxt;
      end
   end

   // Saturating error counter, advanced together with the err_pulse it
   // counts; a clear in the same cycle wins.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         err_cnt_q <= '0;
      end else if (bus.clr_err) begin
         err_cnt_q <= '0;
      end else if (err_pulse_nxt && (err_cnt_q != '1)) begin
         err_cnt_q <= err_cnt_q + ERR_W'(1);
      end
   end

   assign bus.phase      = phase_q;
   assign bus.code_legal = legal_q;
   assign bus.locked     = locked_q;
   assign bus.err_pulse  = err_pulse_q;
   assign bus.wrap_pulse = wrap_pulse_q;
   assign bus.err_count  = err_cnt_q;

endmodule

// File: tb/tb_q_6_24_seq_checker.sv
// ---------------------------------------------------------------------------
// tb_q_6_24_seq_checker
// Self-checking bench for q_6_24_seq_checker: a table of directed vectors
// with hand-derived expectations, hand-written multi-cycle sequences
// (saturation, clear priority, async reset) and a randomized run, all
// checked against a sequence-position reference model.
// ---------------------------------------------------------------------------
module tb_q_6_24_seq_checker;

   localparam int LOCK_CNT   = 3;
   localparam int UNLOCK_CNT = 2;
   localparam int ERR_W      = 8;
   localparam int ERR_MAX    = (1 << ERR_W) - 1;

   localparam int MODE_HUNT   = 0;
   localparam int MODE_VERIFY = 1;
   localparam int MODE_TRACK  = 2;

   logic clk;
   logic rstb;

   int tests_run;
   int tests_failed;

   q_6_24_seq_checker_if #(.ERR_W(ERR_W)) bus ();

   q_6_24_seq_checker #(
      .LOCK_CNT   (LOCK_CNT),
      .UNLOCK_CNT (UNLOCK_CNT),
      .ERR_W      (ERR_W)
   ) dut (
      .clk  (clk),
      .rstb (rstb),
      .bus  (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Sequence order; the index in this table is the phase.
   logic [2:0] seq_codes [6];

   // Reference model state: position-based, prev_idx = -1 means no reference.
   int m_mode;
   int m_prev_idx;
   int m_good;
   int m_bad;
   int m_phase;
   int m_legal;
   int m_locked;
   int m_errp;
   int m_wrapp;
   int m_cnt;

   typedef struct {
      logic       en;
      logic [2:0] code;
      logic       clr;
      logic [2:0] ph;
      logic       lg;
      logic       lk;
      logic       ep;
      logic       wp;
      logic [7:0] cnt;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic en, input logic [2:0] code, input logic clr,
                               input logic [2:0] ph, input logic lg, input logic lk,
                               input logic ep, input logic wp, input logic [7:0] cnt);
      vec_t v;
      v.en = en; v.code = code; v.clr = clr; v.ph = ph; v.lg = lg;
      v.lk = lk; v.ep = ep; v.wp = wp; v.cnt = cnt;
      return v;
   endfunction

   function automatic int findIdx(input logic [2:0] code);
      for (int i = 0; i < 6; i++) begin
         if (seq_codes[i] == code) return i;
      end
      return -1;
   endfunction

   task automatic modelReset();
      m_mode     = MODE_HUNT;
      m_prev_idx = -1;
      m_good     = 0;
      m_bad      = 0;
      m_phase    = 7;
      m_legal    = 0;
      m_locked   = 0;
      m_errp     = 0;
      m_wrapp    = 0;
      m_cnt      = 0;
   endtask

   task automatic modelStep(input logic en, input logic [2:0] code, input logic clr);
      int idx;
      int nxt;
      m_errp  = 0;
      m_wrapp = 0;
      if (en) begin
         idx     = findIdx(code);
         nxt     = (m_prev_idx >= 0) ? (m_prev_idx + 1) % 6 : -1;
         m_phase = (idx < 0) ? 7 : idx;
         m_legal = (idx >= 0) ? 1 : 0;
         if (m_mode == MODE_HUNT) begin
            if (idx >= 0) begin
               m_mode     = MODE_VERIFY;
               m_prev_idx = idx;
               m_good     = 0;
            end
         end else if (m_mode == MODE_VERIFY) begin
            if (idx < 0) begin
               m_mode     = MODE_HUNT;
               m_prev_idx = -1;
            end else if (idx == nxt) begin
               m_good++;
               m_prev_idx = idx;
               if (m_good == LOCK_CNT) begin
                  m_mode = MODE_TRACK;
                  m_bad  = 0;
               end
            end else begin
               m_good     = 0;
               m_prev_idx = idx;
            end
         end else begin
            if (idx == nxt) begin
               m_bad      = 0;
               m_wrapp    = (idx == 0) ? 1 : 0;
               m_prev_idx = idx;
            end else begin
               m_errp     = 1;
               m_bad++;
               m_prev_idx = nxt;
               if (m_bad == UNLOCK_CNT) begin
                  m_mode     = MODE_HUNT;
                  m_prev_idx = -1;
               end
            end
         end
      end
      m_locked = (m_mode == MODE_TRACK) ? 1 : 0;
      if (clr) m_cnt = 0;
      else if (m_errp != 0 && m_cnt < ERR_MAX) m_cnt++;
   endtask

   task automatic applyStimulus(input logic en, input logic [2:0] code, input logic clr);
      @(negedge clk);
      bus.en      = en;
      bus.code_in = code;
      bus.clr_err = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [2:0] ph, input logic lg,
                              input logic lk, input logic ep, input logic wp,
                              input logic [7:0] cnt);
      tests_run++;
      if (bus.phase !== ph || bus.code_legal !== lg || bus.locked !== lk ||
          bus.err_pulse !== ep || bus.wrap_pulse !== wp || bus.err_count !== cnt) begin
         tests_failed++;
         $display("[TB] FAIL %s: got ph=%0d lg=%b lk=%b ep=%b wp=%b cnt=%0d, expected ph=%0d lg=%b lk=%b ep=%b wp=%b cnt=%0d",
                  name, bus.phase, bus.code_legal, bus.locked, bus.err_pulse,
                  bus.wrap_pulse, bus.err_count, ph, lg, lk, ep, wp, cnt);
      end
   endtask

   task automatic runModel(input string name, input logic en, input logic [2:0] code,
                           input logic clr);
      applyStimulus(en, code, clr);
      modelStep(en, code, clr);
      checkOutput(name, 3'(m_phase), 1'(m_legal), 1'(m_locked), 1'(m_errp),
                  1'(m_wrapp), 8'(m_cnt));
   endtask

   task automatic doReset();
      @(negedge clk);
      rstb        = 1'b0;
      bus.en      = 1'b0;
      bus.code_in = 3'b000;
      bus.clr_err = 1'b0;
      modelReset();
      @(posedge clk);
      #1;
      checkOutput("reset", 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
      @(negedge clk);
      rstb = 1'b1;
   endtask

   task automatic lockUp();
      runModel("lock0", 1'b1, 3'b000, 1'b0);
      runModel("lock1", 1'b1, 3'b001, 1'b0);
      runModel("lock2", 1'b1, 3'b011, 1'b0);
      runModel("lock3", 1'b1, 3'b111, 1'b0);
   endtask

   // One error followed by the code the flywheel expects, so lock is kept.
   task automatic errorAndRecover(input string name);
      runModel(name, 1'b1, 3'b010, 1'b0);
      runModel(name, 1'b1, seq_codes[(m_prev_idx + 1) % 6], 1'b0);
   endtask

   initial begin
      int gi;
      logic       r_en;
      logic [2:0] r_code;
      logic       r_clr;

      tests_run    = 0;
      tests_failed = 0;
      seq_codes    = '{3'b000, 3'b001, 3'b011, 3'b111, 3'b110, 3'b100};
      rstb         = 1'b0;
      bus.en       = 1'b0;
      bus.code_in  = 3'b000;
      bus.clr_err  = 1'b0;
      modelReset();

      // Directed vectors: en, code, clr -> phase, legal, locked, err, wrap, count
      vecs.push_back(mk(1, 3'b101, 0, 7, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 3'b000, 0, 0, 1, 0, 0, 0, 0));
      vecs.push_back(mk(1, 3'b001, 0, 1, 1, 0, 0, 0, 0));
      vecs.push_back(mk(1, 3'b011, 0, 2, 1, 0, 0, 0, 0));
      vecs.push_back(mk(1, 3'b111, 0, 3, 1, 1, 0, 0, 0));
      vecs.push_back(mk(1, 3'b110, 0, 4, 1, 1, 0, 0, 0));
      vecs.push_back(mk(1, 3'b100, 0, 5, 1, 1, 0, 0, 0));
      vecs.push_back(mk(1, 3'b000, 0, 0, 1, 1, 0, 1, 0));
      vecs.push_back(mk(1, 3'b001, 0, 1, 1, 1, 0, 0, 0));
      vecs.push_back(mk(1, 3'b010, 0, 7, 0, 1, 1, 0, 1));
      vecs.push_back(mk(1, 3'b111, 0, 3, 1, 1, 0, 0, 1));
      vecs.push_back(mk(1, 3'b110, 0, 4, 1, 1, 0, 0, 1));
      vecs.push_back(mk(1, 3'b100, 0, 5, 1, 1, 0, 0, 1));
      vecs.push_back(mk(1, 3'b000, 0, 0, 1, 1, 0, 1, 1));
      vecs.push_back(mk(1, 3'b110, 0, 4, 1, 1, 1, 0, 2));
      vecs.push_back(mk(1, 3'b110, 0, 4, 1, 0, 1, 0, 3));
      vecs.push_back(mk(1, 3'b000, 0, 0, 1, 0, 0, 0, 3));
      vecs.push_back(mk(1, 3'b001, 0, 1, 1, 0, 0, 0, 3));
      vecs.push_back(mk(1, 3'b011, 0, 2, 1, 0, 0, 0, 3));
      vecs.push_back(mk(1, 3'b111, 0, 3, 1, 1, 0, 0, 3));
      vecs.push_back(mk(0, 3'b101, 0, 3, 1, 1, 0, 0, 3));
      vecs.push_back(mk(0, 3'b010, 0, 3, 1, 1, 0, 0, 3));
      vecs.push_back(mk(1, 3'b110, 0, 4, 1, 1, 0, 0, 3));
      vecs.push_back(mk(0, 3'b000, 0, 4, 1, 1, 0, 0, 3));
      vecs.push_back(mk(1, 3'b100, 0, 5, 1, 1, 0, 0, 3));
      vecs.push_back(mk(1, 3'b010, 1, 7, 0, 1, 1, 0, 0));
      vecs.push_back(mk(1, 3'b001, 0, 1, 1, 1, 0, 0, 0));

      doReset();
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].en, vecs[i].code, vecs[i].clr);
         checkOutput($sformatf("vec%0d", i), vecs[i].ph, vecs[i].lg, vecs[i].lk,
                     vecs[i].ep, vecs[i].wp, vecs[i].cnt);
      end

      // Saturation: drive the counter to all-ones, then one more error.
      doReset();
      lockUp();
      for (int i = 0; i < ERR_MAX; i++) errorAndRecover("sat_fill");
      runModel("sat_hold", 1'b1, 3'b101, 1'b0);
      checkOutput("sat_value", 3'd7, 1'b0, 1'b1, 1'b1, 1'b0, 8'd255);
      runModel("sat_recover", 1'b1, seq_codes[(m_prev_idx + 1) % 6], 1'b0);
      runModel("clr_vs_err", 1'b1, 3'b010, 1'b1);
      checkOutput("clr_value", 3'd7, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0);

      // Async reset while locked with a non-zero count, between clock edges.
      doReset();
      lockUp();
      for (int i = 0; i < 5; i++) errorAndRecover("pre_arst");
      checkOutput("pre_arst_cnt", 3'(m_phase), 1'b1, 1'b1, 1'b0, 1'b0, 8'd5);
      @(negedge clk);
      #1;
      rstb = 1'b0;
      #1;
      modelReset();
      checkOutput("async_reset", 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
      @(negedge clk);
      rstb = 1'b1;

      // Randomized run: a mostly-clean generator with corruption, slips,
      // en gaps and occasional clears.
      gi = 0;
      for (int i = 0; i < 3000; i++) begin
         r_en  = ($urandom_range(0, 9) != 0);
         r_clr = ($urandom_range(0, 49) == 0);
         if ($urandom_range(0, 99) < 85) r_code = seq_codes[gi];
         else                            r_code = 3'($urandom);
         if (r_en) begin
            gi = (gi + 1) % 6;
            if ($urandom_range(0, 99) < 3) gi = (gi + 1) % 6;
         end
         runModel("random", r_en, r_code, r_clr);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
